// File: rtl/huffman_decoder_canon.sv
// huffman_decoder_canon
//   Table-programmable canonical Huffman decoder. It accepts one code bit per
//   cycle, MSB of the code first, and walks the canonical code book one length
//   at a time. Decoded symbols go into a single-entry registered output buffer
//   with valid/ready handshaking.
//
//   The code book is written at run time through a small write port:
//     cfg_sel = 0 : count table, cfg_addr = code length 1..MAX_LEN,
//                   cfg_data = number of codes of that length
//     cfg_sel = 1 : symbol table, cfg_addr = index 0..NSYM-1,
//                   cfg_data = symbol value
//   Writes to an out-of-range address are dropped. Any write also discards a
//   partially received code.
//
//   Optional feature macro: HUFFDEC_ERR_EN
//     defined   : an invalid code (no match at MAX_LEN bits, or a matched index
//                 >= NSYM) pulses err for one cycle and emits no symbol.
//     undefined : err is tied low. A MAX_LEN miss silently restarts the walk,
//                 and an index >= NSYM emits symbol 0 with the code length.
//
// Ports
//   clk, rst              clock, asynchronous active-high reset
//   in_valid, in, in_ready  code bit stream (bit taken when valid && ready)
//   out_valid, out_ready    decoded symbol handshake
//   out_sym, out_len        decoded symbol and its code length
//   cfg_we, cfg_sel, cfg_addr, cfg_data   table write port
//   err                   one-cycle pulse on an invalid code
//
// States
//   state  | meaning
//   IDLE   | no code bits held (len = 0)
//   ACC    | partial code held, len bits received

module huffman_decoder_canon #(
  parameter int MAX_LEN = 8,
  parameter int NSYM    = 18,
  parameter int SYM_W   = 6,
  localparam int LEN_W  = $clog2(MAX_LEN + 1),
  localparam int ADDR_W = $clog2(((MAX_LEN + 1) > NSYM) ? (MAX_LEN + 1) : NSYM),
  localparam int WALK_W = MAX_LEN + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              in,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [SYM_W-1:0]  out_sym,
  output logic [LEN_W-1:0]  out_len,
  input  logic              cfg_we,
  input  logic              cfg_sel,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [SYM_W-1:0]  cfg_data,
  output logic              err
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_ACC  = 1'b1
  } state_t;

  state_t state, nxt_state;

  logic [WALK_W-1:0] code, nxt_code;
  logic [WALK_W-1:0] first, nxt_first;
  logic [WALK_W-1:0] index, nxt_index;
  logic [LEN_W-1:0]  len, nxt_len;

  logic [SYM_W-1:0] count_tab [1:MAX_LEN];
  logic [SYM_W-1:0] sym_tab   [0:NSYM-1];

  logic              accept;
  logic [LEN_W-1:0]  cur_l;
  logic [WALK_W-1:0] cnt;
  logic [WALK_W-1:0] code_b;
  logic [WALK_W-1:0] diff;
  logic [WALK_W-1:0] sym_idx;
  logic              hit;
  logic              idx_ok;
  logic              at_max;
  logic [SYM_W-1:0]  sym_val;
  logic              load_out;

  logic [31:0] addr_ext;
  logic        cnt_addr_ok;
  logic        sym_addr_ok;

  // Bits are refused while the table is being written or while the output
  // buffer is full and not being drained.
  assign in_ready = !cfg_we && !(out_valid && !out_ready);
  assign accept   = in_valid && in_ready;

  assign addr_ext    = 32'(cfg_addr);
  assign cnt_addr_ok = (addr_ext >= 32'd1) && (addr_ext <= 32'(MAX_LEN));
  assign sym_addr_ok = addr_ext < 32'(NSYM);

  // Canonical walk for the bit currently offered. The subtraction wraps when
  // code' < first, which makes it compare as a miss, as intended.
  always_comb begin
    cur_l   = (state == S_IDLE) ? LEN_W'(1) : len + LEN_W'(1);
    cnt     = WALK_W'(count_tab[cur_l]);
    code_b  = code | WALK_W'(in);
    diff    = code_b - first;
    hit     = diff < cnt;
    sym_idx = index + diff;
    idx_ok  = 32'(sym_idx) < 32'(NSYM);
    at_max  = cur_l == LEN_W'(MAX_LEN);
    sym_val = idx_ok ? sym_tab[sym_idx] : '0;
  end

`ifdef HUFFDEC_ERR_EN
  logic err_set;
`endif

  always_comb begin
    nxt_state = state;
    nxt_code  = code;
    nxt_first = first;
    nxt_index = index;
    nxt_len   = len;
    load_out  = 1'b0;
`ifdef HUFFDEC_ERR_EN
    err_set   = 1'b0;
`endif

    if (cfg_we) begin
      nxt_state = S_IDLE;
      nxt_code  = '0;
      nxt_first = '0;
      nxt_index = '0;
      nxt_len   = '0;
    end else if (accept) begin
      if (hit || at_max) begin
        nxt_state = S_IDLE;
        nxt_code  = '0;
        nxt_first = '0;
        nxt_index = '0;
        nxt_len   = '0;
`ifdef HUFFDEC_ERR_EN
        if (hit && idx_ok) begin
          load_out = 1'b1;
        end else begin
          err_set = 1'b1;
        end
`else
        // Out-of-range index emits symbol 0 (sym_val is forced to 0).
        load_out = hit;
`endif
      end else begin
        nxt_state = S_ACC;
        nxt_index = index + cnt;
        nxt_first = (first + cnt) << 1;
        nxt_code  = code_b << 1;
        nxt_len   = cur_l;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      code  <= '0;
      first <= '0;
      index <= '0;
      len   <= '0;
    end else begin
      state <= nxt_state;
      code  <= nxt_code;
      first <= nxt_first;
      index <= nxt_index;
      len   <= nxt_len;
    end
  end

  // Output buffer: a fresh completion wins over the drain, so a same-cycle
  // reload keeps out_valid high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_sym   <= '0;
      out_len   <= '0;
    end else if (load_out) begin
      out_valid <= 1'b1;
      out_sym   <= sym_val;
      out_len   <= cur_l;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef HUFFDEC_ERR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err <= 1'b0;
    end else begin
      err <= err_set;
    end
  end
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 1; i <= MAX_LEN; i++) begin
        count_tab[i] <= '0;
      end
    end else if (cfg_we && !cfg_sel && cnt_addr_ok) begin
      count_tab[cfg_addr[LEN_W-1:0]] <= cfg_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NSYM; i++) begin
        sym_tab[i] <= '0;
      end
    end else if (cfg_we && cfg_sel && sym_addr_ok) begin
      sym_tab[cfg_addr] <= cfg_data;
    end
  end

endmodule

// File: tb/tb_huffman_decoder_canon.sv
// Directed bench for huffman_decoder_canon: a table of complete codes streamed
// back to back, plus hand-written sequences for stall, error, reset and
// table-write corner cases. A second instance with NSYM=2 covers the
// index-out-of-range case. Build with or without HUFFDEC_ERR_EN.

module tb_huffman_decoder_canon;

  localparam int AW  = $clog2(18);
  localparam int AW2 = $clog2(9);

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic          in_valid = 1'b0;
  logic          bit_in = 1'b0;
  logic          in_ready;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [5:0]    out_sym;
  logic [3:0]    out_len;
  logic          cfg_we = 1'b0;
  logic          cfg_sel = 1'b0;
  logic [AW-1:0] cfg_addr = '0;
  logic [5:0]    cfg_data = '0;
  logic          err;

  logic           in_valid2 = 1'b0;
  logic           bit_in2 = 1'b0;
  logic           in_ready2;
  logic           out_valid2;
  logic           out_ready2 = 1'b1;
  logic [5:0]     out_sym2;
  logic [3:0]     out_len2;
  logic           cfg_we2 = 1'b0;
  logic           cfg_sel2 = 1'b0;
  logic [AW2-1:0] cfg_addr2 = '0;
  logic [5:0]     cfg_data2 = '0;
  logic           err2;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  huffman_decoder_canon dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in(bit_in), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sym(out_sym), .out_len(out_len),
    .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .err(err)
  );

  huffman_decoder_canon #(.MAX_LEN(8), .NSYM(2), .SYM_W(6)) dut2 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid2), .in(bit_in2), .in_ready(in_ready2),
    .out_valid(out_valid2), .out_ready(out_ready2),
    .out_sym(out_sym2), .out_len(out_len2),
    .cfg_we(cfg_we2), .cfg_sel(cfg_sel2), .cfg_addr(cfg_addr2), .cfg_data(cfg_data2),
    .err(err2)
  );

  typedef struct {
    logic [7:0] code;
    int         nbits;
    int         sym;
    int         olen;
  } vec_t;

  vec_t vecs [12];
  int   cnts [8];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cfg_write(input logic sel, input int addr, input int data);
    cfg_we   = 1'b1;
    cfg_sel  = sel;
    cfg_addr = AW'(addr);
    cfg_data = 6'(data);
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  task automatic cfg_write2(input logic sel, input int addr, input int data);
    cfg_we2   = 1'b1;
    cfg_sel2  = sel;
    cfg_addr2 = AW2'(addr);
    cfg_data2 = 6'(data);
    @(posedge clk); #1;
    cfg_we2 = 1'b0;
  endtask

  task automatic load_table();
    for (int l = 1; l <= 8; l++) cfg_write(1'b0, l, cnts[l-1]);
    for (int i = 0; i < 18; i++) cfg_write(1'b1, i, i + 1);
  endtask

  task automatic send_bit(input logic b);
    in_valid = 1'b1;
    bit_in   = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_bit2(input logic b);
    in_valid2 = 1'b1;
    bit_in2   = b;
    @(posedge clk); #1;
    in_valid2 = 1'b0;
  endtask

  initial begin
    cnts = '{0, 3, 1, 0, 0, 3, 9, 2};
    vecs[0]  = '{8'b00000000, 2, 1, 2};
    vecs[1]  = '{8'b00000110, 3, 4, 3};
    vecs[2]  = '{8'b00111000, 6, 5, 6};
    vecs[3]  = '{8'b01110111, 7, 9, 7};
    vecs[4]  = '{8'b11111111, 8, 18, 8};
    vecs[5]  = '{8'b00000001, 2, 2, 2};
    vecs[6]  = '{8'b00000010, 2, 3, 2};
    vecs[7]  = '{8'b00111001, 6, 6, 6};
    vecs[8]  = '{8'b00111010, 6, 7, 6};
    vecs[9]  = '{8'b01110110, 7, 8, 7};
    vecs[10] = '{8'b01111110, 7, 16, 7};
    vecs[11] = '{8'b11111110, 8, 17, 8};

    #12;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_sym", int'(out_sym), 0);
    chk("rst_out_len", int'(out_len), 0);
    chk("rst_err", int'(err), 0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("idle_in_ready", int'(in_ready), 1);

    load_table();

    // Back-to-back code stream
    for (int v = 0; v < 12; v++) begin
      for (int k = vecs[v].nbits - 1; k >= 0; k--) begin
        send_bit(vecs[v].code[k]);
        if (k != 0) chk($sformatf("v%0d_mid_valid", v), int'(out_valid), 0);
      end
      chk($sformatf("v%0d_valid", v), int'(out_valid), 1);
      chk($sformatf("v%0d_sym", v), int'(out_sym), vecs[v].sym);
      chk($sformatf("v%0d_len", v), int'(out_len), vecs[v].olen);
      chk($sformatf("v%0d_err", v), int'(err), 0);
    end
    @(posedge clk); #1;
    chk("drain_valid", int'(out_valid), 0);

    // Back-pressure: hold symbol 2, stall the next bit, then resume with code 10
    out_ready = 1'b0;
    send_bit(1'b0);
    send_bit(1'b1);
    chk("stall_valid", int'(out_valid), 1);
    chk("stall_sym", int'(out_sym), 2);
    in_valid = 1'b1;
    bit_in   = 1'b1;
    #1;
    chk("stall_in_ready", int'(in_ready), 0);
    @(posedge clk); #1;
    chk("stall_hold_valid", int'(out_valid), 1);
    chk("stall_hold_sym", int'(out_sym), 2);
    chk("stall_hold_len", int'(out_len), 2);
    out_ready = 1'b1;
    #1;
    chk("resume_in_ready", int'(in_ready), 1);
    @(posedge clk); #1;
    chk("resume_valid_clr", int'(out_valid), 0);
    send_bit(1'b0);
    chk("resume_valid", int'(out_valid), 1);
    chk("resume_sym", int'(out_sym), 3);
    chk("resume_len", int'(out_len), 2);

    // All-zero counts: every 8-bit string is invalid; the 9th bit restarts
    for (int l = 1; l <= 8; l++) cfg_write(1'b0, l, 0);
    for (int n = 1; n <= 16; n++) begin
      send_bit(1'b1);
`ifdef HUFFDEC_ERR_EN
      chk($sformatf("zero_err_%0d", n), int'(err), (n == 8 || n == 16) ? 1 : 0);
`else
      chk($sformatf("zero_err_%0d", n), int'(err), 0);
`endif
      chk($sformatf("zero_valid_%0d", n), int'(out_valid), 0);
    end
    @(posedge clk); #1;
    chk("zero_err_after", int'(err), 0);
    load_table();

    // Index beyond NSYM on the 2-entry instance
    for (int l = 1; l <= 8; l++) cfg_write2(1'b0, l, cnts[l-1]);
    cfg_write2(1'b1, 0, 1);
    cfg_write2(1'b1, 1, 2);
    cfg_write2(1'b1, 2, 9);
    send_bit2(1'b0);
    send_bit2(1'b1);
    chk("n2_ok_valid", int'(out_valid2), 1);
    chk("n2_ok_sym", int'(out_sym2), 2);
    send_bit2(1'b1);
    send_bit2(1'b0);
`ifdef HUFFDEC_ERR_EN
    chk("n2_oor_err", int'(err2), 1);
    chk("n2_oor_valid", int'(out_valid2), 0);
    @(posedge clk); #1;
    chk("n2_oor_err_pulse", int'(err2), 0);
`else
    chk("n2_oor_err", int'(err2), 0);
    chk("n2_oor_valid", int'(out_valid2), 1);
    chk("n2_oor_sym", int'(out_sym2), 0);
    chk("n2_oor_len", int'(out_len2), 2);
`endif

    // Reset with a symbol pending
    out_ready = 1'b0;
    send_bit(1'b0);
    send_bit(1'b1);
    chk("prst_valid", int'(out_valid), 1);
    rst = 1'b1;
    #1;
    chk("prst_out_valid", int'(out_valid), 0);
    chk("prst_out_sym", int'(out_sym), 0);
    chk("prst_out_len", int'(out_len), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    load_table();

    // Reset mid-code: tables are cleared, so 00 decodes nothing until reload
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b1);
    rst = 1'b1;
    #1;
    chk("mrst_out_valid", int'(out_valid), 0);
    chk("mrst_out_sym", int'(out_sym), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    send_bit(1'b0);
    send_bit(1'b0);
    chk("mrst_00_valid", int'(out_valid), 0);
    chk("mrst_00_sym", int'(out_sym), 0);
    load_table();
    send_bit(1'b0);
    send_bit(1'b0);
    chk("reload_valid", int'(out_valid), 1);
    chk("reload_sym", int'(out_sym), 1);
    chk("reload_len", int'(out_len), 2);

    // Table write mid-code discards the partial code silently
    send_bit(1'b1);
    send_bit(1'b1);
    in_valid = 1'b1;
    bit_in   = 1'b1;
    cfg_we   = 1'b1;
    cfg_sel  = 1'b1;
    cfg_addr = AW'(0);
    cfg_data = 6'd1;
    #1;
    chk("cfg_in_ready", int'(in_ready), 0);
    @(posedge clk); #1;
    cfg_we   = 1'b0;
    in_valid = 1'b0;
    chk("cfg_valid", int'(out_valid), 0);
    chk("cfg_err", int'(err), 0);
    send_bit(1'b0);
    send_bit(1'b0);
    chk("cfg_00_valid", int'(out_valid), 1);
    chk("cfg_00_sym", int'(out_sym), 1);
    chk("cfg_00_err", int'(err), 0);

    @(posedge clk); #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/huffman_decoder_canon.md
# huffman_decoder_canon

Parametrised, table-programmable canonical Huffman decoder that generalises the fixed 18-symbol serial decoder. It consumes one code bit per cycle over a valid/ready stream and emits decoded symbols over a registered valid/ready output. The code book is loaded at run time as per-length code counts plus a symbol list, so any canonical code up to `MAX_LEN` bits can be decoded. It sits between the serial bit source and the symbol consumer in the decode datapath.

## Interface
- `MAX_LEN`, 8: longest code length in bits; lengths 1..`MAX_LEN`.
- `NSYM`, 18: symbol-table depth.
- `SYM_W`, 6: symbol width; must be ≥ clog2(`NSYM`+1).
- `clk`  in  1  clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  a code bit is offered on `in`.
- `in`  in  1  code bit, MSB of code first.
- `in_ready`  out  1  bit accepted when `in_valid && in_ready`.
- `out_valid`  out  1  `out_sym` holds a decoded symbol.
- `out_ready`  in  1  consumer accepts the symbol.
- `out_sym`  out  `SYM_W`  decoded symbol value.
- `out_len`  out  clog2(`MAX_LEN`+1)  length of the decoded code.
- `cfg_we`  in  1  table write strobe.
- `cfg_sel`  in  1  0 = count table (addr = length 1..`MAX_LEN`), 1 = symbol table (addr = index 0..`NSYM`-1).
- `cfg_addr`  in  clog2(max(`MAX_LEN`+1,`NSYM`))  write address.
- `cfg_data`  in  `SYM_W`  count or symbol value.
- `err`  out  1  one-cycle pulse on an invalid code.

## Operation
- Reset: `out_valid`=0, `out_sym`=0, `out_len`=0, `err`=0, decode state cleared (code=0, first=0, index=0, len=0). Count and symbol tables are reset to 0.
- Canonical walk, per accepted bit at length L=len+1:
  - code' = code | bit.
  - If code' − first < count[L], the code is complete: symbol index = index + (code' − first). Load `out_sym`=sym[index], `out_len`=L, and clear the decode state.
  - Otherwise: index += count[L]; first = (first + count[L]) << 1; code = code' << 1; len = L.
- All walk arithmetic is MAX_LEN+1 bits wide and unsigned.
- Invalid code: no match at L=`MAX_LEN`, or a matched index ≥ `NSYM`. The block pulses `err`, emits no symbol, clears the decode state, and the next bit starts a new code.
- States: IDLE (len=0), ACC (partial code held). Completion or error returns to IDLE. The output buffer is a separate single-entry register.
- `cfg_we`: writes the selected table and clears the decode state. A partially received code is discarded without `err`. The output buffer is unaffected. `in_ready`=0 in a `cfg_we` cycle. Writes with an out-of-range address are ignored.

## Timing
- `in_ready` = !`cfg_we` && !(`out_valid` && !`out_ready`). This is combinational from `out_ready`.
- Latency: the symbol is valid in the cycle after the edge that accepted its final bit.
- Throughput: one bit per cycle, with no bubble between consecutive codes.
- `out_valid` is cleared on `out_ready`, unless a new completion occurs in the same cycle. In that case the buffer reloads and `out_valid` stays 1.
- `out_sym` and `out_len` are held stable while `out_valid && !out_ready`.
- `err` is asserted in the cycle after the offending bit and lasts one cycle.
- Reset mid-code or with a symbol pending drops everything; outputs return to their reset values immediately.

## Configuration
- `HUFFDEC_ERR_EN` defined: invalid-code detection as above, with `err` driven.
- Not defined: `err` is tied 0 and the detection logic is removed. A length-`MAX_LEN` miss silently clears the decode state. An index ≥ `NSYM` emits `out_sym`=0 with `out_len`=L.

## Test plan
- Load counts L1..L8 = {0,3,1,0,0,3,9,2} and symbols[i]=i+1. Stream 00,110,111000,1110111,11111111 back-to-back with `out_ready`=1 → symbols 1,4,5,9,18 with lengths 2,3,6,7,8, each valid one cycle after its last bit.
- With the same table, hold `out_ready`=0 after code 01 → `out_valid`=1, `out_sym`=2. Next bit stalls (`in_ready`=0). Raising `out_ready` resumes; no bit or symbol is lost.
- Load counts all 0 (`HUFFDEC_ERR_EN` on), stream 8 ones → `err` pulses once after the 8th bit. The 9th bit starts a new code.
- With counts {0,3,1,…} but `NSYM`=2, send 10 → index 2 → `err` with the macro; without the macro, `out_sym`=0 and `out_len`=2.
- Assert `rst` after bits 111 of 1110110 → outputs 0. Then send 00 → `out_sym`=0, because the table was cleared and reloading is required. Reload and send 00 → 1.
- Issue `cfg_we` after bits 11 → no output and no `err`. Then 00 → `out_sym`=1.
